// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light controller.
package f1_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_SEQ,
      ST_HOLD,
      ST_TIMING,
      ST_DONE,
      ST_FAULT
   } state_t;

   localparam int                LFSR_W        = 7;
   // Feedback taps for x^7 + x^6 + 1 (bits 6 and 5 of the shift register)
   localparam logic [LFSR_W-1:0] LFSR_TAPS     = 7'b110_0000;
   localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 7'h01;
   localparam int                TICK_DIV_DEF  = 24;
   localparam int                MS_DIV_DEF    = 1;
   localparam int                REACT_W       = 16;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/f1_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR supplying the random lights-out delay.
module f1_lfsr7
   import f1_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst) q <= SEED;
      else      q <= lfsr_next(q);
   end

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start controller: drives the light sequencer, applies a random hold
// before lights-out, then times the driver's reaction or flags a jump start.
module f1_start_ctrl
   import f1_pkg::*;
#(
   parameter int                TICK_DIV  = TICK_DIV_DEF,
   parameter int                MS_DIV    = MS_DIV_DEF,
   parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               react,
   input  logic               seq_active,
   input  logic               seq_full,
   output logic               light_en,
   output logic               light_trig,
   output logic               light_rst,
   output logic [REACT_W-1:0] react_time,
   output logic               result_valid,
   output logic               jump_start,
   output logic               busy
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int MW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [MW-1:0] MS_MAX    = MW'(MS_DIV - 1);

   state_t               state, state_nxt;
   logic [PW-1:0]        presc;
   logic [LFSR_W-1:0]    delay;
   logic [MW-1:0]        ms_cnt;
   logic [REACT_W-1:0]   rt_cnt;
   logic                 jump_flag;
   logic                 fault_new;
   logic [LFSR_W-1:0]    lfsr_val;
   logic                 tick_wrap;
   logic                 full_ok;

   function automatic logic [REACT_W-1:0] sat_inc(input logic [REACT_W-1:0] v);
      return (&v) ? v : v + REACT_W'(1);
   endfunction

   f1_lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_val)
   );

   assign tick_wrap = (presc == PRESC_MAX);
   // Only trust "all lights on" while the sequencer reports it is running.
   assign full_ok   = seq_full & seq_active;

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_ARM;
         ST_ARM:    state_nxt = react ? ST_FAULT : ST_SEQ;
         ST_SEQ: begin
            if (react)        state_nxt = ST_FAULT;
            else if (full_ok) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (react)                                state_nxt = ST_FAULT;
            else if (tick_wrap && delay == 7'd1)      state_nxt = ST_TIMING;
         end
         ST_TIMING: if (react) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         ST_FAULT:  if (!react) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc     <= '0;
         delay     <= '0;
         ms_cnt    <= '0;
         rt_cnt    <= '0;
         jump_flag <= 1'b0;
         fault_new <= 1'b0;
      end else begin
         fault_new <= (state_nxt == ST_FAULT) && (state != ST_FAULT);

         if (state_nxt != state)
            presc <= '0;
         else if (state == ST_SEQ || state == ST_HOLD)
            presc <= tick_wrap ? '0 : presc + PW'(1);

         if (state == ST_SEQ && state_nxt == ST_HOLD)
            delay <= lfsr_val;
         else if (state == ST_HOLD && tick_wrap)
            delay <= delay - 7'd1;

         if (state_nxt == ST_FAULT)
            jump_flag <= 1'b1;
         else if (state == ST_IDLE && start)
            jump_flag <= 1'b0;

         // The react cycle itself does not count, so the result is the count before it.
         if ((state == ST_IDLE && start) || (state == ST_HOLD && state_nxt == ST_TIMING)) begin
            rt_cnt <= '0;
            ms_cnt <= '0;
         end else if (state == ST_TIMING && !react) begin
            if (ms_cnt == MS_MAX) begin
               ms_cnt <= '0;
               rt_cnt <= sat_inc(rt_cnt);
            end else begin
               ms_cnt <= ms_cnt + MW'(1);
            end
         end
      end
   end

   always_comb begin
      light_en     = 1'b0;
      light_trig   = 1'b0;
      light_rst    = 1'b0;
      result_valid = 1'b0;
      busy         = 1'b0;
      react_time   = rt_cnt;
      jump_start   = jump_flag;
      if (!rst) begin
         light_rst  = 1'b1;
         react_time = '0;
         jump_start = 1'b0;
      end else begin
         busy = (state != ST_IDLE);
         case (state)
            ST_ARM: begin
               light_trig = 1'b1;
               light_en   = 1'b1;
            end
            ST_SEQ:   light_en     = tick_wrap;
            ST_HOLD:  light_en     = tick_wrap && (delay == 7'd1);
            ST_DONE:  result_valid = 1'b1;
            ST_FAULT: light_rst    = fault_new;
            default:  ;
         endcase
      end
   end

endmodule

// File: doc/f1_start_ctrl.md
F1_START_CTRL -- requirements
Module: f1_start_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 24, clock cycles per light step tick (>=2).
REQ-002 Parameter MS_DIV, default 1, clock cycles per reaction-time count (>=1).
REQ-003 Parameter LFSR_SEED, default 7'h01, non-zero LFSR reset value.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  run request; sampled each cycle.
REQ-007 react  in  1  driver button level, already synchronised.
REQ-008 seq_active  in  1  light sequencer "lights running" flag (S1..S8).
REQ-009 seq_full  in  1  light sequencer "all eight lights on" flag.
REQ-010 light_en  out  1  enable pulse to light sequencer.
REQ-011 light_trig  out  1  trigger to light sequencer.
REQ-012 light_rst  out  1  active-high reset to light sequencer.
REQ-013 react_time  out  16  reaction count, unsigned.
REQ-014 result_valid  out  1  one-cycle pulse, react_time valid.
REQ-015 jump_start  out  1  jump-start flag, level.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, ARM, SEQ, HOLD, TIMING, DONE, FAULT.
REQ-018 IDLE: start=1 -> ARM, clears jump_start and react_time; else stay.
REQ-019 ARM: light_trig=1 and light_en=1 for exactly one cycle, tick prescaler cleared -> SEQ.
REQ-020 SEQ: prescaler counts 0..TICK_DIV-1; light_en=1 only in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
REQ-021 SEQ with seq_full=1 -> HOLD; delay counter loaded with current LFSR value (1..127 ticks); prescaler cleared.
REQ-022 LFSR: 7-bit Fibonacci, x^7+x^6+1, advances every cycle in all states, never zero.
REQ-023 HOLD: light_en=0 except the single lights-out pulse; delay counter decrements on each prescaler wrap; on the wrap where it reaches zero, light_en=1 for one cycle -> TIMING with react_time=0.
REQ-024 TIMING: react_time increments once per MS_DIV cycles and saturates at 16'hFFFF (no wrap).
REQ-025 TIMING with react=1 -> DONE; react_time frozen at the count reached before that cycle; result_valid=1 in the DONE cycle only.
REQ-026 DONE -> IDLE unconditionally.
REQ-027 react=1 in ARM, SEQ or HOLD (including the lights-out pulse cycle) -> FAULT; jump_start=1; light_rst=1 for one cycle; result_valid stays 0.
REQ-028 react and seq_full both high in one SEQ cycle: jump start wins.
REQ-029 FAULT -> IDLE on the first cycle with react=0; jump_start holds until the next accepted start.
REQ-030 start is ignored whenever busy=1.
REQ-031 light_trig is 0 outside ARM; light_en is 0 in IDLE, TIMING, DONE and FAULT.

Reset
REQ-032 While rst=0: state IDLE, prescaler, delay and react counters 0, LFSR=LFSR_SEED, all outputs 0 except light_rst=1.
REQ-033 Reset asserted mid-run aborts without a result_valid pulse; the first cycle after release is IDLE with light_rst=0.

Structure
REQ-034 Package f1_pkg holds the state enum, LFSR width, taps, seed and the default TICK_DIV/MS_DIV constants.
REQ-035 The LFSR is a sub-module f1_lfsr7 (clk, rst, q[6:0]); all other logic is in f1_start_ctrl.

Verification (TICK_DIV=4, MS_DIV=1, LFSR_SEED=7'h01)
REQ-036 Hold rst=0 for 3 cycles -> light_rst=1 and all other outputs 0; after release light_rst=0 and busy=0.
REQ-037 Pulse start; a model sequencer raises seq_full after 8 light_en pulses; assert react in the 11th TIMING cycle -> result_valid pulse, react_time=10, jump_start=0, then IDLE.
REQ-038 Assert react during HOLD -> jump_start=1, one-cycle light_rst, no result_valid; release react -> IDLE next cycle; the next start clears jump_start.
REQ-039 Pulse start again in SEQ and TIMING -> no state change and no extra light_trig.
REQ-040 Never assert react in TIMING for 70000 cycles -> react_time=16'hFFFF, still TIMING, busy=1.
REQ-041 Assert rst=0 mid-HOLD -> IDLE, light_rst=1 during reset, counters 0, no result_valid.
